// File: rtl/mux_pipe.sv
// Registered N-way word selector with valid/ready flow control.
// One output register plus a skid register; in_ready depends only on state, never on out_ready.
module mux_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } beat_t;

  localparam logic [31:0] NUM_IN_U = 32'(NUM_IN);

  logic [NUM_IN-1:0][WIDTH-1:0] masked;
  beat_t sel_beat, main_q, skid_q;
  logic  skid_valid, main_free, in_xfer;

  // Each input contributes its word only when selected; OR-reduce picks the winner.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_sel
    assign masked[i] = (in_sel == SEL_W'(i)) ? in_data[i*WIDTH +: WIDTH] : '0;
  end

  always_comb begin
    sel_beat     = '0;
    sel_beat.err = (32'(in_sel) >= NUM_IN_U);
    for (int i = 0; i < NUM_IN; i++) sel_beat.data = sel_beat.data | masked[i];
  end

  assign in_ready  = !skid_valid && !rst;
  assign in_xfer   = in_valid && in_ready;
  assign main_free = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_xfer) begin
        main_q    <= sel_beat;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;  // data/err keep their last value
      end
    end else if (in_xfer) begin
      skid_q     <= sel_beat;
      skid_valid <= 1'b1;
    end
  end

  assign out_data    = main_q.data;
  assign out_sel_err = main_q.err;

endmodule
